// File: rtl/video_dvi_pkg.sv
// Shared definitions for the DVI output path: symbol widths, TMDS control
// symbols, the disparity counter type and small encoding helpers.
package video_dvi_pkg;

  localparam int unsigned COLOR_W = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned QM_W    = 9;
  localparam int unsigned SYM_W   = 10;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned ONES_W  = 4;

  localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

  // Running disparity of the emitted stream, two's complement -16..+15.
  typedef logic signed [CNT_W-1:0] disp_t;

  // Stage-1 payload: transition-minimised word plus its aligned controls.
  typedef struct packed {
    logic            de;
    logic            c1;
    logic            c0;
    logic [QM_W-1:0] q_m;
  } qm_word_t;

  function automatic logic [ONES_W-1:0] ones8(input logic [DATA_W-1:0] v);
    logic [ONES_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      n = n + ONES_W'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [SYM_W-1:0] ctrl_symbol(input logic c1, input logic c0);
    logic [SYM_W-1:0] s;
    case ({c1, c0})
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/video_dvi_tmds_encoder.sv
// One TMDS channel: stage 1 minimises transitions, stage 2 balances DC and
// registers the 10-bit symbol. Controls travel alongside the data.
module tmds_encoder
  import video_dvi_pkg::*;
(
  input  logic              vga_clk,
  input  logic              vga_rst,
  input  logic [DATA_W-1:0] data,
  input  logic              c0,
  input  logic              c1,
  input  logic              de,
  output logic [SYM_W-1:0]  symbol
);

  localparam disp_t EIGHT = 5'sd8;

  logic [ONES_W-1:0] n1_d;
  logic              use_xnor;
  logic              acc;
  logic [QM_W-1:0]   q_m_c;
  qm_word_t          st1_q;

  logic [ONES_W-1:0] n1_q;
  logic              q8;
  logic [DATA_W-1:0] q;
  logic              more_ones;
  logic              more_zeros;
  logic              cnt_neg;
  logic              cnt_pos;
  disp_t             diff;
  disp_t             two_q8;
  disp_t             two_nq8;
  disp_t             cnt_q;
  disp_t             cnt_c;
  logic [SYM_W-1:0]  sym_c;

  // XNOR chain equals the XOR chain with every odd bit flipped.
  always_comb begin
    n1_d     = ones8(data);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
    q_m_c    = '0;
    acc      = data[0];
    q_m_c[0] = data[0];
    for (int unsigned i = 1; i < DATA_W; i++) begin
      acc      = acc ^ data[i];
      q_m_c[i] = acc ^ (use_xnor & (i % 2 == 1));
    end
    q_m_c[QM_W-1] = ~use_xnor;
  end

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      st1_q <= '0;
    end else begin
      st1_q <= '{de: de, c1: c1, c0: c0, q_m: q_m_c};
    end
  end

  // cnt tracks the exact disparity of the symbols already sent on this line.
  always_comb begin
    sym_c      = CTRL_00;
    cnt_c      = '0;
    q8         = st1_q.q_m[QM_W-1];
    q          = st1_q.q_m[DATA_W-1:0];
    n1_q       = ones8(q);
    more_ones  = n1_q > 4'd4;
    more_zeros = n1_q < 4'd4;
    diff       = $signed({n1_q, 1'b0}) - EIGHT;
    two_q8     = $signed({3'b000, q8, 1'b0});
    two_nq8    = $signed({3'b000, ~q8, 1'b0});
    cnt_neg    = cnt_q[CNT_W-1];
    cnt_pos    = !cnt_neg && (cnt_q != '0);

    if (!st1_q.de) begin
      sym_c = ctrl_symbol(st1_q.c1, st1_q.c0);
      cnt_c = '0;
    end else if ((cnt_q == '0) || (!more_ones && !more_zeros)) begin
      sym_c = {~q8, q8, q8 ? q : ~q};
      cnt_c = q8 ? (cnt_q + diff) : (cnt_q - diff);
    end else if ((cnt_pos && more_ones) || (cnt_neg && more_zeros)) begin
      sym_c = {1'b1, q8, ~q};
      cnt_c = cnt_q + two_q8 - diff;
    end else begin
      sym_c = {1'b0, q8, q};
      cnt_c = cnt_q + diff - two_nq8;
    end
  end

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      symbol <= CTRL_00;
      cnt_q  <= '0;
    end else begin
      symbol <= sym_c;
      cnt_q  <= cnt_c;
    end
  end

endmodule

// File: rtl/video_dvi.sv
// VGA-to-DVI front end: widens 4-bit colour, conditions sync polarity and
// feeds three TMDS encoders; syncs ride on the blue channel.
module video_dvi
  import video_dvi_pkg::*;
#(
  parameter bit SYNC_INVERT = 1'b1
) (
  input  logic               vga_clk,
  input  logic               vga_rst,
  input  logic [COLOR_W-1:0] vga_r,
  input  logic [COLOR_W-1:0] vga_g,
  input  logic [COLOR_W-1:0] vga_b,
  input  logic               vga_hsync,
  input  logic               vga_vsync,
  input  logic               vga_de,
  output logic [SYM_W-1:0]   tmds_red,
  output logic [SYM_W-1:0]   tmds_green,
  output logic [SYM_W-1:0]   tmds_blue
);

  logic hs_enc;
  logic vs_enc;

  assign hs_enc = vga_hsync ^ SYNC_INVERT;
  assign vs_enc = vga_vsync ^ SYNC_INVERT;

  tmds_encoder u_enc_red (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .data    ({vga_r, vga_r}),
    .c0      (1'b0),
    .c1      (1'b0),
    .de      (vga_de),
    .symbol  (tmds_red)
  );

  tmds_encoder u_enc_green (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .data    ({vga_g, vga_g}),
    .c0      (1'b0),
    .c1      (1'b0),
    .de      (vga_de),
    .symbol  (tmds_green)
  );

  tmds_encoder u_enc_blue (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .data    ({vga_b, vga_b}),
    .c0      (hs_enc),
    .c1      (vs_enc),
    .de      (vga_de),
    .symbol  (tmds_blue)
  );

endmodule

// File: tb/tb_video_dvi.sv
// Randomised bench for video_dvi against an integer-arithmetic TMDS model,
// plus directed reset, blanking-edge and sync-edge scenarios.
module tb_video_dvi;

  localparam bit SINV = 1'b1;

  logic       vga_clk = 1'b0;
  logic       vga_rst;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync, vga_de;
  logic [9:0] tmds_red, tmds_green, tmds_blue;

  int n_vec = 0;
  int n_err = 0;

  int ctrl_tab[4] = '{'h354, 'h0AB, 'h154, 'h2AB};

  int mcnt[3];
  int pend_sym[3], pend_d[3];
  bit pend_de;
  int exp_sym[3], exp_d[3];
  bit exp_de;
  int run_disp[3];
  int peak;
  bit line_open;
  int active;

  always #5 vga_clk = ~vga_clk;

  video_dvi #(.SYNC_INVERT(SINV)) dut (
    .vga_clk    (vga_clk),
    .vga_rst    (vga_rst),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .vga_de     (vga_de),
    .tmds_red   (tmds_red),
    .tmds_green (tmds_green),
    .tmds_blue  (tmds_blue)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder straight from the TMDS rules, in plain integers.
  function automatic void tmds_ref(input int d, input int cnt_in, output int sym, output int cnt_out);
    int n1, xn, q, b, q8, n1q, n0q, qi;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += (d >> i) & 1;
    xn = (n1 > 4 || (n1 == 4 && (d & 1) == 0)) ? 1 : 0;
    q = d & 1;
    for (int i = 1; i < 8; i++) begin
      b = ((q >> (i - 1)) & 1) ^ ((d >> i) & 1) ^ xn;
      q |= b << i;
    end
    q8 = 1 - xn;
    n1q = 0;
    for (int i = 0; i < 8; i++) n1q += (q >> i) & 1;
    n0q = 8 - n1q;
    qi = (~q) & 'hFF;
    cnt_out = cnt_in;
    if (cnt_in == 0 || n1q == n0q) begin
      sym = ((1 - q8) << 9) | (q8 << 8) | (q8 != 0 ? q : qi);
      cnt_out += (q8 != 0) ? (n1q - n0q) : (n0q - n1q);
    end else if ((cnt_in > 0 && n1q > n0q) || (cnt_in < 0 && n0q > n1q)) begin
      sym = 512 | (q8 << 8) | qi;
      cnt_out += 2 * q8 + n0q - n1q;
    end else begin
      sym = (q8 << 8) | q;
      cnt_out += (n1q - n0q) - 2 * (1 - q8);
    end
  endfunction

  function automatic logic [31:0] decode(input logic [9:0] s);
    logic [7:0] qd, d;
    qd = s[9] ? ~s[7:0] : s[7:0];
    d = '0;
    d[0] = qd[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (qd[i] ^ qd[i-1]) : ~(qd[i] ^ qd[i-1]);
    return 32'(d);
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      mcnt[ch] = 0;
      pend_sym[ch] = 'h354;
      pend_d[ch] = 0;
      exp_sym[ch] = 'h354;
      exp_d[ch] = 0;
      run_disp[ch] = 0;
    end
    pend_de = 1'b0;
    exp_de = 1'b0;
    peak = 0;
    line_open = 1'b0;
  endtask

  // Whatever is sampled now emerges one edge after the next.
  task automatic model_edge();
    int col[3];
    int c0, c1, s, cn;
    col[0] = int'(vga_r) * 17;
    col[1] = int'(vga_g) * 17;
    col[2] = int'(vga_b) * 17;
    exp_sym = pend_sym;
    exp_d = pend_d;
    exp_de = pend_de;
    for (int ch = 0; ch < 3; ch++) begin
      c0 = (ch == 2) ? int'(vga_hsync ^ SINV) : 0;
      c1 = (ch == 2) ? int'(vga_vsync ^ SINV) : 0;
      if (vga_de) begin
        tmds_ref(col[ch], mcnt[ch], s, cn);
        pend_sym[ch] = s;
        mcnt[ch] = cn;
      end else begin
        pend_sym[ch] = ctrl_tab[c1 * 2 + c0];
        mcnt[ch] = 0;
      end
      pend_d[ch] = col[ch];
    end
    pend_de = vga_de;
  endtask

  task automatic cycle();
    logic [9:0] got[3];
    int a;
    @(posedge vga_clk);
    model_edge();
    #1;
    got[0] = tmds_red;
    got[1] = tmds_green;
    got[2] = tmds_blue;
    for (int ch = 0; ch < 3; ch++) check($sformatf("symbol_ch%0d", ch), 32'(got[ch]), exp_sym[ch]);
    if (exp_de) begin
      for (int ch = 0; ch < 3; ch++) begin
        check($sformatf("decode_ch%0d", ch), decode(got[ch]), exp_d[ch]);
        run_disp[ch] += 2 * $countones(got[ch]) - 10;
        a = (run_disp[ch] < 0) ? -run_disp[ch] : run_disp[ch];
        if (a > peak) peak = a;
      end
    end else if (line_open) begin
      check("disparity_peak", (peak <= 10) ? 0 : peak, 0);
      for (int ch = 0; ch < 3; ch++) run_disp[ch] = 0;
      peak = 0;
    end
    line_open = exp_de;
  endtask

  task automatic set_in(input bit de, input logic [3:0] r, input logic [3:0] g,
                        input logic [3:0] b, input bit hs, input bit vs);
    vga_de = de;
    vga_r = r;
    vga_g = g;
    vga_b = b;
    vga_hsync = hs;
    vga_vsync = vs;
  endtask

  task automatic set_rand_pixel(input bit hs, input bit vs);
    set_in(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), hs, vs);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hs, vs;
    int len, blank;

    vga_rst = 1'b1;
    set_in(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    check("reset_red", 32'(tmds_red), 'h354);
    check("reset_green", 32'(tmds_green), 'h354);
    check("reset_blue", 32'(tmds_blue), 'h354);
    vga_rst = 1'b0;

    // Blanking with both syncs low: inverted syncs give the 11 control on blue.
    cycle();
    cycle();
    check("blank_blue", 32'(tmds_blue), 'h2AB);
    check("blank_red", 32'(tmds_red), 'h354);
    check("blank_green", 32'(tmds_green), 'h354);

    // Four black pixels after blanking.
    for (int i = 0; i < 6; i++) begin
      set_in(i < 4, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      cycle();
      if (i >= 1 && i <= 4) begin
        check("black_red", 32'(tmds_red), (i % 2 == 1) ? 'h100 : 'h3FF);
        check("black_green", 32'(tmds_green), (i % 2 == 1) ? 'h100 : 'h3FF);
        check("black_blue", 32'(tmds_blue), (i % 2 == 1) ? 'h100 : 'h3FF);
      end
    end

    // Single white pixel followed immediately by blanking.
    set_in(1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    cycle();
    set_in(1'b0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    cycle();
    check("white_red", 32'(tmds_red), 'h200);
    check("white_blue", 32'(tmds_blue), 'h200);
    cycle();
    check("white_then_ctrl_blue", 32'(tmds_blue), 'h2AB);
    check("white_then_ctrl_green", 32'(tmds_green), 'h354);

    // hsync edge coincident with DE fall, then vsync mid-blank.
    for (int i = 0; i < 3; i++) begin
      set_rand_pixel(1'b0, 1'b0);
      cycle();
    end
    set_in(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    cycle();
    check("hs_edge_blue_pre", 32'(tmds_blue[9:8] == 2'b10 && tmds_blue == 10'h154), 0);
    cycle();
    check("hs_edge_blue", 32'(tmds_blue), 'h154);
    cycle();
    set_in(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    cycle();
    check("vs_edge_blue_pre", 32'(tmds_blue), 'h154);
    cycle();
    check("vs_edge_blue", 32'(tmds_blue), 'h354);
    set_in(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    cycle();
    cycle();

    // Random lines, including one-pixel lines and one-cycle gaps.
    active = 0;
    hs = 1'b0;
    vs = 1'b0;
    while (active < 10000) begin
      len = $urandom_range(1, 48);
      blank = $urandom_range(1, 6);
      for (int i = 0; i < blank; i++) begin
        if ($urandom_range(0, 3) == 0) hs = ~hs;
        if ($urandom_range(0, 15) == 0) vs = ~vs;
        set_in(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), hs, vs);
        cycle();
      end
      for (int i = 0; i < len; i++) begin
        set_rand_pixel(hs, vs);
        cycle();
        active++;
      end
    end

    // Reset in the middle of a line acts at once; next line restarts at cnt = 0.
    for (int i = 0; i < 5; i++) begin
      set_rand_pixel(1'b0, 1'b0);
      cycle();
    end
    vga_rst = 1'b1;
    #2;
    check("midline_rst_red", 32'(tmds_red), 'h354);
    check("midline_rst_green", 32'(tmds_green), 'h354);
    check("midline_rst_blue", 32'(tmds_blue), 'h354);
    model_reset();
    @(posedge vga_clk);
    #1;
    vga_rst = 1'b0;
    set_in(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    cycle();
    cycle();
    set_in(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    cycle();
    cycle();
    check("fresh_line_red", 32'(tmds_red), 'h100);
    check("fresh_line_blue", 32'(tmds_blue), 'h100);
    set_in(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_dvi.md
VIDEO_DVI -- requirements
Module: video_dvi

Interface
REQ-001 Parameter SYNC_INVERT, default 1, inverts hsync/vsync before encoding (640x480 uses negative sync).
REQ-002 vga_clk  input  1  pixel clock; all logic on its rising edge.
REQ-003 vga_rst  input  1  reset, asynchronous, active-high.
REQ-004 vga_r / vga_g / vga_b  input  4 each  pixel colour from the VGA output stage.
REQ-005 vga_hsync / vga_vsync  input  1 each  active-high sync pulses, aligned with colour.
REQ-006 vga_de  input  1  data enable: high during active pixels, aligned with colour.
REQ-007 tmds_red / tmds_green / tmds_blue  output  10 each  TMDS symbols for an external 10:1 serializer.

Function
REQ-008 Each 4-bit colour shall expand to 8 bits by nibble replication, {c,c}: 0x0 -> 0x00, 0xF -> 0xFF.
REQ-009 Blue shall carry C0 = hsync and C1 = vsync, after optional inversion; green and red shall carry C0 = C1 = 0.
REQ-010 Each channel shall be a 2-stage pipeline: stage 1 produces the 9-bit transition-minimised word q_m; stage 2 applies DC balancing and registers the output.
REQ-011 Stage 1 shall count N1(D); if N1 > 4, or N1 == 4 with D[0] == 0, it shall use the XNOR chain with q_m[8] = 0; otherwise it shall use the XOR chain with q_m[8] = 1; q_m[0] = D[0].
REQ-012 Stage 2 shall keep a per-channel signed disparity counter cnt, 5 bits, with range -16..+15, which is sufficient.
REQ-013 If cnt == 0 or N1(q_m[7:0]) == N0(q_m[7:0]):
- out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
- cnt += q_m[8] ? (N1 - N0) : (N0 - N1)
REQ-014 Else if (cnt > 0 and N1 > N0) or (cnt < 0 and N0 > N1):
- out = {1, q_m[8], ~q_m[7:0]}
- cnt += 2*q_m[8] + (N0 - N1)
REQ-015 Otherwise:
- out = {0, q_m[8], q_m[7:0]}
- cnt += (N1 - N0) - 2*(~q_m[8])
REQ-016 When DE is low at stage 2, the output shall be the control symbol for {C1,C0}:
- 00 = 1101010100
- 01 = 0010101011
- 10 = 0101010100
- 11 = 1010101011
- cnt shall be forced to 0.
REQ-017 DE, C0 and C1 shall be delayed by the same 2 cycles as colour.
- Total input-to-output latency: exactly 2 vga_clk cycles for data and control.
- Skew between the three outputs: none.
REQ-018 On a DE 0->1 transition, the first data symbol shall be encoded with cnt = 0.
REQ-019 On a DE 1->0 transition, the control symbol shall appear on the cycle after the last data symbol, with no gap symbol.
REQ-020 Single-cycle DE pulses and single-cycle blanking gaps shall be encoded correctly, with no symbol lost or duplicated.

Reset
REQ-021 On vga_rst, all pipeline registers and cnt shall clear to 0.
- Each output shall be the 00 control symbol, 1101010100.
- Delayed DE shall be 0.
REQ-022 Reset asserted mid-line shall take effect immediately (asynchronously).
REQ-023 After reset is released, the first valid symbol shall appear 2 cycles after the first sampled input.

Structure
REQ-024 The four control symbols and the cnt width shall live in the shared video package, video_dvi_pkg.
REQ-025 One sub-module, tmds_encoder, shall encode one channel (8-bit data, C0, C1, DE; 10-bit symbol), instantiated three times.
- video_dvi contains only expansion, sync inversion and wiring.

Verification
REQ-026 Reset held, then released with DE = 0, hsync = vsync = 0, SYNC_INVERT = 1:
- blue = 1010101011 (C1 = C0 = 1)
- red/green = 1101010100
REQ-027 DE = 1 with all colours 0x0 for 4 pixels after blanking:
- each output, 2 cycles later, = 0x100, 0x3FF, 0x100, 0x3FF
REQ-028 DE = 1, single pixel 0xF/0xF/0xF after blanking:
- each output = 0x200 two cycles later
- then a control symbol on the next cycle
REQ-029 Random colours over 10,000 active pixels checked against a reference encoder model:
- every symbol matches
- running disparity per line stays within +/-10
- a decoder recovers the original data
REQ-030 hsync toggled on the cycle DE falls, and vsync asserted mid-blank:
- blue control symbol changes exactly 2 cycles after each input edge
REQ-031 vga_rst pulsed in the middle of an active line:
- all outputs = 1101010100 within the same cycle
- a fresh line after release starts with cnt = 0
